multi_bank_wbuf_arb: RTL and testbench

MULTI_BANK_WBUF_ARB -- requirements
Module: multi_bank_wbuf_arb

---
 rtl/multi_bank_wbuf_arb_pkg.sv | 20 ++
 rtl/multi_bank_wbuf_arb_tdp_bank.sv | 33 +++
 rtl/multi_bank_wbuf_arb.sv | 206 ++++++++++++++++++++
 tb/tb_multi_bank_wbuf_arb.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_bank_wbuf_arb_pkg.sv
// Shared defaults and types for the multi-bank weight buffer.
//   N_BANK_DFLT / DEPTH_DFLT / DATA_W_DFLT : default geometry
//   bank_idx_t / blk_addr_t / blk_t          : bank index, block address, block payload
//   port_sel_e                               : which bank port served a read
package wbuf_pkg;

  localparam int N_BANK_DFLT = 6;
  localparam int DEPTH_DFLT  = 11;
  localparam int DATA_W_DFLT = 256;

  typedef logic [$clog2(N_BANK_DFLT)-1:0] bank_idx_t;
  typedef logic [$clog2(DEPTH_DFLT)-1:0]  blk_addr_t;
  typedef logic [DATA_W_DFLT-1:0]         blk_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_sel_e;

endpackage

// File: rtl/multi_bank_wbuf_arb_tdp_bank.sv
// One dual-port weight bank with registered read outputs.
//   clk               : clock
//   a_we/a_addr/a_wdata/a_rdata : port A, read/write, read-first
//   b_addr/b_rdata    : port B, read only
// The array model here stands in for the BRAM macro, which exposes the same ports.
// Contents are intentionally not reset.
module wbuf_tdp_bank
  import wbuf_pkg::*;
#(
  parameter  int DEPTH  = DEPTH_DFLT,
  parameter  int DATA_W = DATA_W_DFLT,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Non-blocking write plus read of the same location yields the old word
  // on both ports (read-first).
  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_wdata;
    a_rdata <= mem[a_addr];
    b_rdata <= mem[b_addr];
  end

endmodule

// File: rtl/multi_bank_wbuf_arb.sv
// Multi-bank weight buffer: one write port, N_RD read channels, each bank dual-ported.
//   clk, rst_n                     : clock, async active-low reset
//   wr_valid/wr_ready              : write handshake (never stalls out of reset)
//   wr_bank/wr_addr/wr_data        : write target and payload
//   wr_err                         : pulse, previous accepted write was out of range
//   rd_valid/rd_ready              : per-channel read handshake (flattened vectors)
//   rd_bank/rd_addr                : per-channel read target
//   rd_rvalid/rd_rdata/rd_err      : per-channel response, RD_LAT after accept
//   conflict_cnt                   : saturating count of cycles with a refused read
module multi_bank_wbuf_arb
  import wbuf_pkg::*;
#(
  parameter  int N_BANK = N_BANK_DFLT,
  parameter  int DEPTH  = DEPTH_DFLT,
  parameter  int DATA_W = DATA_W_DFLT,
  parameter  int N_RD   = 4,
  parameter  int RD_LAT = 2,
  localparam int BANK_W = $clog2(N_BANK),
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [BANK_W-1:0]        wr_bank,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_err,
  input  logic [N_RD-1:0]          rd_valid,
  output logic [N_RD-1:0]          rd_ready,
  input  logic [N_RD*BANK_W-1:0]   rd_bank,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr,
  output logic [N_RD-1:0]          rd_rvalid,
  output logic [N_RD*DATA_W-1:0]   rd_rdata,
  output logic [N_RD-1:0]          rd_err,
  output logic [15:0]              conflict_cnt
);

  logic              wr_acc;
  logic              wr_oor;
  logic [N_BANK-1:0] wr_hit;

  logic [BANK_W-1:0] rd_bank_a [N_RD];
  logic [ADDR_W-1:0] rd_addr_a [N_RD];
  logic [N_RD-1:0]   rd_oor;
  port_sel_e         grant_port [N_RD];

  logic [1:0]        ports_used [N_BANK];
  logic [N_BANK-1:0] a_we;
  logic [ADDR_W-1:0] a_addr [N_BANK];
  logic [ADDR_W-1:0] b_addr [N_BANK];
  logic [DATA_W-1:0] a_q [N_BANK];
  logic [DATA_W-1:0] b_q [N_BANK];

  assign wr_ready = rst_n;
  assign wr_acc   = wr_valid & rst_n;
  assign wr_oor   = (32'(wr_bank) >= N_BANK) || (32'(wr_addr) >= DEPTH);

  always_comb begin
    for (int j = 0; j < N_RD; j++) begin
      rd_bank_a[j] = rd_bank[j*BANK_W +: BANK_W];
      rd_addr_a[j] = rd_addr[j*ADDR_W +: ADDR_W];
      rd_oor[j]    = (32'(rd_bank_a[j]) >= N_BANK) || (32'(rd_addr_a[j]) >= DEPTH);
    end
  end

  // Port allocation: an in-range write owns port A of its bank; reads then take
  // the free ports in channel-index order. Out-of-range reads need no port.
  always_comb begin
    for (int b = 0; b < N_BANK; b++) begin
      wr_hit[b]     = wr_acc && !wr_oor && (wr_bank == BANK_W'(b));
      ports_used[b] = wr_hit[b] ? 2'd1 : 2'd0;
      a_we[b]       = wr_hit[b];
      a_addr[b]     = wr_hit[b] ? wr_addr : '0;
      b_addr[b]     = '0;
    end
    for (int j = 0; j < N_RD; j++) begin
      rd_ready[j]   = 1'b0;
      grant_port[j] = PORT_A;
      if (rst_n && rd_valid[j]) begin
        if (rd_oor[j]) begin
          rd_ready[j] = 1'b1;
        end else begin
          for (int b = 0; b < N_BANK; b++) begin
            if (rd_bank_a[j] == BANK_W'(b) && ports_used[b] != 2'd2) begin
              rd_ready[j] = 1'b1;
              if (ports_used[b] == 2'd0) begin
                grant_port[j] = PORT_A;
                a_addr[b]     = rd_addr_a[j];
              end else begin
                grant_port[j] = PORT_B;
                b_addr[b]     = rd_addr_a[j];
              end
              ports_used[b] = ports_used[b] + 2'd1;
            end
          end
        end
      end
    end
  end

  for (genvar b = 0; b < N_BANK; b++) begin : g_bank
    wbuf_tdp_bank #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
    ) u_bank (
      .clk     (clk),
      .a_we    (a_we[b]),
      .a_addr  (a_addr[b]),
      .a_wdata (wr_data),
      .a_rdata (a_q[b]),
      .b_addr  (b_addr[b]),
      .b_rdata (b_q[b])
    );
  end

  // Stage 0: request metadata aligned with the bank output register.
  logic [N_RD-1:0]   s0_valid;
  logic [N_RD-1:0]   s0_err;
  port_sel_e         s0_port [N_RD];
  logic [BANK_W-1:0] s0_bank [N_RD];
  logic [DATA_W-1:0] s1_data [N_RD];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid <= '0;
      s0_err   <= '0;
      for (int j = 0; j < N_RD; j++) begin
        s0_port[j] <= PORT_A;
        s0_bank[j] <= '0;
      end
    end else begin
      s0_valid <= rd_valid & rd_ready;
      s0_err   <= rd_valid & rd_ready & rd_oor;
      for (int j = 0; j < N_RD; j++) begin
        s0_port[j] <= grant_port[j];
        s0_bank[j] <= rd_bank_a[j];
      end
    end
  end

  // Steer the bank word to its channel. Idle and error slots carry zero so the
  // later stages never need their own data masking.
  always_comb begin
    for (int j = 0; j < N_RD; j++) begin
      s1_data[j] = '0;
      if (s0_valid[j] && !s0_err[j]) begin
        for (int b = 0; b < N_BANK; b++) begin
          if (s0_bank[j] == BANK_W'(b))
            s1_data[j] = (s0_port[j] == PORT_B) ? b_q[b] : a_q[b];
        end
      end
    end
  end

  // Bank outputs change every cycle, so the steered word is captured right away
  // and shifted with its valid/err for the remaining RD_LAT-1 stages.
  if (RD_LAT == 1) begin : g_lat1
    always_comb begin
      rd_rvalid = s0_valid;
      rd_err    = s0_err;
      for (int j = 0; j < N_RD; j++) rd_rdata[j*DATA_W +: DATA_W] = s1_data[j];
    end
  end else begin : g_latn
    logic [N_RD-1:0]   p_valid [RD_LAT-1];
    logic [N_RD-1:0]   p_err   [RD_LAT-1];
    logic [DATA_W-1:0] p_data  [RD_LAT-1][N_RD];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < RD_LAT-1; k++) begin
          p_valid[k] <= '0;
          p_err[k]   <= '0;
          for (int j = 0; j < N_RD; j++) p_data[k][j] <= '0;
        end
      end else begin
        p_valid[0] <= s0_valid;
        p_err[0]   <= s0_err;
        p_data[0]  <= s1_data;
        for (int k = 1; k < RD_LAT-1; k++) begin
          p_valid[k] <= p_valid[k-1];
          p_err[k]   <= p_err[k-1];
          p_data[k]  <= p_data[k-1];
        end
      end
    end

    always_comb begin
      rd_rvalid = p_valid[RD_LAT-2];
      rd_err    = p_err[RD_LAT-2];
      for (int j = 0; j < N_RD; j++) rd_rdata[j*DATA_W +: DATA_W] = p_data[RD_LAT-2][j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err       <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      wr_err <= wr_acc & wr_oor;
      if (|(rd_valid & ~rd_ready) && conflict_cnt != 16'hFFFF)
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_multi_bank_wbuf_arb.sv
// Scoreboard bench for multi_bank_wbuf_arb: a reference model decides acceptance
// and response contents from bank port capacity, and a negedge monitor compares.
module tb_multi_bank_wbuf_arb;
  import wbuf_pkg::*;

  localparam int N_BANK = 6;
  localparam int DEPTH  = 11;
  localparam int DATA_W = 256;
  localparam int N_RD   = 4;
  localparam int RD_LAT = 2;
  localparam int BANK_W = 3;
  localparam int ADDR_W = 4;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [BANK_W-1:0]      wr_bank;
  logic [ADDR_W-1:0]      wr_addr;
  logic [DATA_W-1:0]      wr_data;
  logic                   wr_err;
  logic [N_RD-1:0]        rd_valid;
  logic [N_RD-1:0]        rd_ready;
  logic [N_RD*BANK_W-1:0] rd_bank;
  logic [N_RD*ADDR_W-1:0] rd_addr;
  logic [N_RD-1:0]        rd_rvalid;
  logic [N_RD*DATA_W-1:0] rd_rdata;
  logic [N_RD-1:0]        rd_err;
  logic [15:0]            conflict_cnt;

  always #5 clk = ~clk;

  multi_bank_wbuf_arb #(
    .N_BANK(N_BANK), .DEPTH(DEPTH), .DATA_W(DATA_W), .N_RD(N_RD), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_err(wr_err),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_bank(rd_bank), .rd_addr(rd_addr),
    .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata), .rd_err(rd_err),
    .conflict_cnt(conflict_cnt)
  );

  typedef struct packed {
    logic [31:0]       due;
    logic              err;
    logic [DATA_W-1:0] data;
  } resp_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [DATA_W-1:0] ref_mem [N_BANK][DEPTH];
  resp_t             exp_q [N_RD][$];
  int                ref_cnt = 0;
  logic              ref_wr_err = 1'b0;
  logic [N_RD-1:0]   acc = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model + monitor, evaluated mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int j = 0; j < N_RD; j++) exp_q[j].delete();
        ref_cnt    = 0;
        ref_wr_err = 1'b0;
        acc        = '0;
        chk("rst_rvalid", rd_rvalid, '0);
        chk("rst_rdata", rd_rdata[DATA_W-1:0] | rd_rdata[2*DATA_W-1:DATA_W]
                         | rd_rdata[3*DATA_W-1:2*DATA_W] | rd_rdata[4*DATA_W-1:3*DATA_W], '0);
        chk("rst_rd_err", rd_err, '0);
        chk("rst_wr_err", wr_err, '0);
        chk("rst_conflict_cnt", conflict_cnt, '0);
        chk("rst_rd_ready", rd_ready, '0);
        chk("rst_wr_ready", wr_ready, '0);
      end else begin
        int cap [N_BANK];
        logic [N_RD-1:0] exp_ready;
        bit w_oor;

        for (int j = 0; j < N_RD; j++) begin
          if (exp_q[j].size() > 0 && exp_q[j][0].due == cyc) begin
            resp_t r;
            r = exp_q[j].pop_front();
            chk($sformatf("rvalid[%0d]", j), rd_rvalid[j], 1'b1);
            chk($sformatf("rdata[%0d]", j), rd_rdata[j*DATA_W +: DATA_W], r.data);
            chk($sformatf("rd_err[%0d]", j), rd_err[j], r.err);
          end else begin
            chk($sformatf("idle_rvalid[%0d]", j), rd_rvalid[j], 1'b0);
            chk($sformatf("idle_rdata[%0d]", j), rd_rdata[j*DATA_W +: DATA_W], '0);
            chk($sformatf("idle_rd_err[%0d]", j), rd_err[j], 1'b0);
          end
        end
        chk("wr_err", wr_err, ref_wr_err);
        chk("conflict_cnt", conflict_cnt, 16'(ref_cnt));

        w_oor = (int'(wr_bank) >= N_BANK) || (int'(wr_addr) >= DEPTH);
        for (int b = 0; b < N_BANK; b++) cap[b] = 2;
        if (wr_valid && !w_oor) cap[wr_bank] = 1;
        exp_ready = '0;
        for (int j = 0; j < N_RD; j++) begin
          int rb, ra;
          rb = int'(rd_bank[j*BANK_W +: BANK_W]);
          ra = int'(rd_addr[j*ADDR_W +: ADDR_W]);
          if (rd_valid[j]) begin
            if (rb >= N_BANK || ra >= DEPTH) exp_ready[j] = 1'b1;
            else if (cap[rb] > 0) begin
              exp_ready[j] = 1'b1;
              cap[rb]--;
            end
          end
        end
        chk("rd_ready", rd_ready, exp_ready);
        chk("wr_ready", wr_ready, 1'b1);

        for (int j = 0; j < N_RD; j++) begin
          if (exp_ready[j]) begin
            resp_t r;
            int rb, ra;
            rb = int'(rd_bank[j*BANK_W +: BANK_W]);
            ra = int'(rd_addr[j*ADDR_W +: ADDR_W]);
            r.due = 32'(cyc + RD_LAT);
            r.err = (rb >= N_BANK || ra >= DEPTH);
            r.data = r.err ? '0 : ref_mem[rb][ra];
            exp_q[j].push_back(r);
          end
        end
        if (|(rd_valid & ~exp_ready) && ref_cnt < 65535) ref_cnt++;
        ref_wr_err = wr_valid && w_oor;
        if (wr_valid && !w_oor) ref_mem[wr_bank][wr_addr] = wr_data;
        acc = exp_ready;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int j, input bit v, input int b, input int a);
    rd_valid[j] = v;
    rd_bank[j*BANK_W +: BANK_W] = BANK_W'(b);
    rd_addr[j*ADDR_W +: ADDR_W] = ADDR_W'(a);
  endtask

  task automatic set_wr(input bit v, input int b, input int a, input logic [DATA_W-1:0] d);
    wr_valid = v;
    wr_bank  = BANK_W'(b);
    wr_addr  = ADDR_W'(a);
    wr_data  = d;
  endtask

  function automatic logic [DATA_W-1:0] rand_blk();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic int rand_bank();
    if ($urandom_range(0, 19) == 0) return $urandom_range(6, 7);
    if ($urandom_range(0, 1) == 1) return $urandom_range(0, 1);
    return $urandom_range(0, 5);
  endfunction

  function automatic int rand_addr();
    if ($urandom_range(0, 19) == 0) return $urandom_range(11, 15);
    return $urandom_range(0, 10);
  endfunction

  initial begin
    logic [DATA_W-1:0] d0, d1;
    d0 = {32{8'hD0}};
    d1 = {32{8'hD1}};
    wr_valid = 1'b0; wr_bank = '0; wr_addr = '0; wr_data = '0;
    rd_valid = '0; rd_bank = '0; rd_addr = '0;
    repeat (3) step();
    rst_n = 1'b1;

    // Fill every in-range location so later reads have defined data.
    for (int b = 0; b < N_BANK; b++)
      for (int a = 0; a < DEPTH; a++) begin
        set_wr(1'b1, b, a, {8{32'h5EED_0000 + 32'(b*16 + a)}});
        step();
      end
    set_wr(1'b0, 0, 0, '0);
    step();

    // Write then read back two cycles later.
    set_wr(1'b1, 2, 5, {32{8'hA5}});
    step();
    set_wr(1'b0, 0, 0, '0);
    step();
    set_rd(0, 1'b1, 2, 5);
    step();
    set_rd(0, 1'b0, 0, 0);
    repeat (3) step();

    // Four channels on one bank: two ports, lowest channels win.
    for (int j = 0; j < N_RD; j++) set_rd(j, 1'b1, 1, j);
    @(negedge clk);
    chk("bank1_all_ready", rd_ready, 4'b0011);
    step();
    set_rd(0, 1'b0, 0, 0);
    set_rd(1, 1'b0, 0, 0);
    @(negedge clk);
    chk("bank1_held_ready", rd_ready, 4'b1100);
    chk("bank1_conflict_cnt", conflict_cnt, 16'd1);
    step();
    rd_valid = '0;
    repeat (3) step();

    // Write occupies port A; simultaneous read sees old data, second read refused.
    set_wr(1'b1, 3, 0, d0);
    step();
    set_wr(1'b1, 3, 0, d1);
    set_rd(0, 1'b1, 3, 0);
    set_rd(1, 1'b1, 3, 0);
    @(negedge clk);
    chk("rw_same_ready", rd_ready, 4'b0001);
    step();
    set_wr(1'b0, 0, 0, '0);
    set_rd(0, 1'b0, 0, 0);
    @(negedge clk);
    chk("rw_held_ready", rd_ready, 4'b0010);
    step();
    rd_valid = '0;
    repeat (3) step();

    // Out-of-range read and write.
    set_rd(2, 1'b1, 0, 12);
    set_wr(1'b1, 7, 0, '1);
    @(negedge clk);
    chk("oor_rd_ready", rd_ready, 4'b0100);
    step();
    set_rd(2, 1'b0, 0, 0);
    set_wr(1'b0, 0, 0, '0);
    @(negedge clk);
    chk("oor_wr_err_pulse", wr_err, 1'b1);
    step();
    @(negedge clk);
    chk("oor_wr_err_clear", wr_err, 1'b0);
    step();
    for (int a = 0; a < 4; a++) set_rd(a, 1'b1, a, 0);
    step();
    rd_valid = '0;
    repeat (3) step();

    // Reset one cycle after four accepts: no late responses, counters cleared.
    for (int j = 0; j < N_RD; j++) set_rd(j, 1'b1, j + 1, j);
    step();
    rd_valid = '0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (4) step();
    @(negedge clk);
    chk("post_rst_conflict_cnt", conflict_cnt, 16'd0);
    step();

    // Randomized traffic, holding refused requests stable.
    for (int c = 0; c < 3000; c++) begin
      for (int j = 0; j < N_RD; j++) begin
        if (!rd_valid[j] || acc[j]) begin
          if ($urandom_range(0, 99) < 65) set_rd(j, 1'b1, rand_bank(), rand_addr());
          else set_rd(j, 1'b0, 0, 0);
        end
      end
      if ($urandom_range(0, 1) == 1) set_wr(1'b1, rand_bank(), rand_addr(), rand_blk());
      else set_wr(1'b0, 0, 0, '0);
      if (c == 1500) begin
        rd_valid = '0;
        set_wr(1'b0, 0, 0, '0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      step();
    end

    rd_valid = '0;
    set_wr(1'b0, 0, 0, '0);
    repeat (RD_LAT + 4) step();
    for (int j = 0; j < N_RD; j++)
      chk($sformatf("drain_q[%0d]", j), 32'(exp_q[j].size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
